// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit, one bit per cycle
// Shift-add multiply and restoring divide share one 2*XLEN accumulator.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [2:0]      op;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0] opnd;
    logic            neg_res;

    logic            sign_a, sign_b;
    logic [XLEN-1:0] abs_a, abs_b;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] special_val;
    logic [XLEN-1:0] min_int;

    assign min_int = {1'b1, {(XLEN-1){1'b0}}};

    always_comb begin
        sign_a      = op_a[XLEN-1] & (funct3 == 3'd1 || funct3 == 3'd2 ||
                                      funct3 == 3'd4 || funct3 == 3'd6);
        sign_b      = op_b[XLEN-1] & (funct3 == 3'd1 || funct3 == 3'd4 || funct3 == 3'd6);
        abs_a       = sign_a ? ('0 - op_a) : op_a;
        abs_b       = sign_b ? ('0 - op_b) : op_b;
        div_zero    = funct3[2] && (op_b == '0);
        div_ovf     = (funct3 == 3'd4 || funct3 == 3'd6) && (op_a == min_int) && (op_b == '1);
        special_val = '0;
        if (div_zero)
            special_val = funct3[1] ? op_a : '1;
        else
            special_val = funct3[1] ? '0 : min_int;
    end

    // Multiply: acc = {partial product, remaining multiplier bits}
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    // Divide: acc = {partial remainder, remaining dividend / quotient bits}
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_inv;
    logic [XLEN+1:0]   div_sub;
    logic              div_ge;
    logic [2*XLEN-1:0] div_next;
    logic              unused_sub_bit;

    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_next = {mul_sum, acc[XLEN-1:1]};
        div_shift = acc[2*XLEN-1:XLEN-1];
        div_inv   = ~{1'b0, opnd};
        div_sub   = {1'b0, div_shift} + {1'b0, div_inv} + {{(XLEN+1){1'b0}}, 1'b1};
        div_ge    = div_sub[XLEN+1];
        div_next  = {div_ge ? div_sub[XLEN-1:0] : div_shift[XLEN-1:0], acc[XLEN-2:0], div_ge};
    end

    assign unused_sub_bit = div_sub[XLEN];

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   fix_val;

    always_comb begin
        prod    = neg_res ? ('0 - acc) : acc;
        fix_val = '0;
        case (op)
            3'd0:                fix_val = prod[XLEN-1:0];
            3'd1, 3'd2, 3'd3:    fix_val = prod[2*XLEN-1:XLEN];
            3'd4, 3'd5:          fix_val = neg_res ? ('0 - acc[XLEN-1:0]) : acc[XLEN-1:0];
            default:             fix_val = neg_res ? ('0 - acc[2*XLEN-1:XLEN]) : acc[2*XLEN-1:XLEN];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            count   <= '0;
            op      <= '0;
            acc     <= '0;
            opnd    <= '0;
            neg_res <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (!flush && start) begin
                        op <= funct3;
                        if (div_zero || div_ovf) begin
                            result <= special_val;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            acc     <= {{XLEN{1'b0}}, funct3[2] ? abs_a : abs_b};
                            opnd    <= funct3[2] ? abs_b : abs_a;
                            neg_res <= (funct3 == 3'd6 || funct3 == 3'd7) ? sign_a : (sign_a ^ sign_b);
                            count   <= CW'(XLEN);
                            busy    <= 1'b1;
                            state   <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (flush) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        acc   <= op[2] ? div_next : mul_next;
                        count <= count - CW'(1);
                        if (count == CW'(1))
                            state <= FIX;
                    end
                end
                FIX: begin
                    busy <= 1'b0;
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        result <= fix_val;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed vector bench for muldiv_unit
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic        busy, done;
    logic [31:0] result;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result)
    );

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output int busy_cyc,
                         output logic done_after);
        @(negedge clk);
        start = 1'b1; funct3 = f; op_a = a; op_b = b;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        busy_cyc = busy ? 1 : 0;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (busy) busy_cyc++;
        end
        res = result;
        @(posedge clk); #1;
        done_after = done;
    endtask

    task automatic watch_no_done(input string name, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        check(name, {31'b0, seen}, 32'd0);
    endtask

    initial begin
        logic [31:0] res;
        int          lat, bc, n;
        logic        da;

        rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = 3'd0; op_a = '0; op_b = '0;
        #12;
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset result", result, 32'd0);
        @(negedge clk); rst = 1'b0;

        vecs.push_back('{3'd0, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB, 34});
        vecs.push_back('{3'd1, 32'h80000000,  32'hFFFFFFFF, 32'h00000000, 34});
        vecs.push_back('{3'd2, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 34});
        vecs.push_back('{3'd3, 32'h80000000,  32'hFFFFFFFF, 32'h7FFFFFFF, 34});
        vecs.push_back('{3'd4, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD, 34});
        vecs.push_back('{3'd6, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, 34});
        vecs.push_back('{3'd5, 32'd100,       32'd7,        32'd14,       34});
        vecs.push_back('{3'd7, 32'd100,       32'd7,        32'd2,        34});
        vecs.push_back('{3'd5, 32'd5,         32'd0,        32'hFFFFFFFF, 1});
        vecs.push_back('{3'd6, 32'd5,         32'd0,        32'd5,        1});
        vecs.push_back('{3'd4, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1});
        vecs.push_back('{3'd6, 32'h80000000,  32'hFFFFFFFF, 32'd0,        1});
        vecs.push_back('{3'd4, 32'd0,         32'd0,        32'hFFFFFFFF, 1});
        vecs.push_back('{3'd7, 32'h12345678,  32'd0,        32'h12345678, 1});
        vecs.push_back('{3'd0, 32'd0,         32'd12345,    32'd0,        34});
        vecs.push_back('{3'd3, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFE, 34});
        vecs.push_back('{3'd1, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'd0,        34});
        vecs.push_back('{3'd0, 32'h12345678,  32'h10,       32'h23456780, 34});
        vecs.push_back('{3'd4, 32'd7,         32'hFFFFFFFE, 32'hFFFFFFFD, 34});
        vecs.push_back('{3'd6, 32'd7,         32'hFFFFFFFE, 32'd1,        34});

        foreach (vecs[i]) begin
            do_op(vecs[i].f, vecs[i].a, vecs[i].b, res, lat, bc, da);
            check($sformatf("vec%0d result", i), res, vecs[i].exp);
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d busy cycles", i), 32'(bc), (vecs[i].lat == 34) ? 32'd33 : 32'd0);
            check($sformatf("vec%0d done width", i), {31'b0, da}, 32'd0);
        end

        // flush at the 10th CALC edge: back to IDLE, result untouched, no done
        do_op(3'd0, 32'd6, 32'd7, res, lat, bc, da);
        check("pre-flush result", res, 32'd42);
        @(negedge clk);
        start = 1'b1; funct3 = 3'd0; op_a = 32'd3; op_b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        check("flush busy", {31'b0, busy}, 32'd0);
        check("flush result kept", result, 32'd42);
        watch_no_done("flush no done", 40);

        // flush beats start in IDLE
        @(negedge clk); start = 1'b1; flush = 1'b1;
        @(posedge clk); #1; start = 1'b0; flush = 1'b0;
        check("idle flush busy", {31'b0, busy}, 32'd0);
        watch_no_done("idle flush no done", 40);

        do_op(3'd0, 32'd3, 32'd5, res, lat, bc, da);
        check("post-flush mul", res, 32'd15);

        // asynchronous reset mid-CALC
        @(negedge clk);
        start = 1'b1; funct3 = 3'd5; op_a = 32'd100; op_b = 32'd7;
        @(posedge clk); #1; start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async rst busy", {31'b0, busy}, 32'd0);
        check("async rst result", result, 32'd0);
        @(negedge clk); rst = 1'b0;
        watch_no_done("async rst no done", 40);

        // start held high: DONE ignores it, IDLE accepts the next one
        @(negedge clk);
        start = 1'b1; funct3 = 3'd5; op_a = 32'd100; op_b = 32'd7;
        @(posedge clk); #1;
        n = 1;
        while (!done && n < 100) begin @(posedge clk); #1; n++; end
        check("held start latency", 32'(n), 32'd34);
        check("held start result", result, 32'd14);
        @(posedge clk); #1;
        check("held start DONE ignores", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
        check("held start IDLE accepts", {31'b0, busy}, 32'd1);
        start = 1'b0;
        n = 1;
        while (!done && n < 100) begin @(posedge clk); #1; n++; end
        check("second op latency", 32'(n), 32'd34);
        check("second op result", result, 32'd14);
        @(posedge clk); #1;

        // start pulses with new operands while busy
        @(negedge clk);
        start = 1'b1; funct3 = 3'd4; op_a = 32'hFFFFFF9C; op_b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        while (!done && n < 100) begin
            if (n % 3 == 0) begin
                start = 1'b1; funct3 = 3'd0; op_a = $urandom; op_b = $urandom;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        check("busy-start latency", 32'(n), 32'd34);
        check("busy-start result", result, 32'hFFFFFFF2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
